hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard and flush controller for the 5-stage MIPS datapath. Sits beside the ID stage, upstream of the control-word pipeline registers. It tracks which destination registers are still in flight in EX and MEM and detects read-after-write hazards on the instruction in ID. It then drives the control word's pass/bubble select, PC and IF/ID write enables, and flushes for taken branches and jumps.

## Interface
- REG_ADDR_W, 5, register-specifier width
- CNT_W, 16, width of the saturating event counters
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  IF/ID holds a real instruction (0 after flush)
- id_rs, id_rt  in  REG_ADDR_W  source specifiers of the ID instruction
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_reg_write  in  1  ID instruction writes the register file
- id_mem_read  in  1  ID instruction is a load
- id_dst  in  REG_ADDR_W  resolved destination (after regDst select)
- id_j, id_jr  in  1  jump / jump-register decoded in ID
- mem_branch_taken  in  1  branch resolved taken in MEM this cycle
- stall  out  1  control-word select: 1 = ID control word passes into ID/EX, 0 = bubble (all-zero) inserted
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID register load enable
- flush_ifid, flush_idex, flush_exmem  out  1  synchronous clear of that pipeline register at next posedge
- stall_cycles  out  CNT_W  saturating count of bubble cycles
- flush_events  out  CNT_W  saturating count of redirect events (taken branch or jump)

## Operation
- Scoreboard: two slots, EX and MEM, each {valid, dst, is_load}. WB slot not kept: register file writes first half-cycle, reads second half, so a WB writer is already visible to ID.
- Match: source X hazards against slot S when id_valid & id_uses_X & S.valid & S.dst == id_X & id_X != 0. Register $0 never hazards.
- Hazard (FORWARD_EN off): any match against EX or MEM. jr always evaluates rs this way, independent of FORWARD_EN; ID has no forward path.
- On hazard: stall=0, pc_write=0, ifid_write=0. Instruction held in IF/ID; bubble enters EX.
- Otherwise: stall=1, pc_write=1, ifid_write=1.
- id_j or id_jr without hazard:
  - flush_ifid=1, so the fall-through fetch is squashed.
  - The jump itself passes (stall=1).
  - flush_events increments.
- mem_branch_taken has highest priority:
  - flush_ifid=flush_idex=flush_exmem=1, pc_write=1, stall=0.
  - Hazard and jump terms are ignored that cycle.
  - flush_events increments once, even if id_j is also set.
- Slot update at posedge:
  - MEM <= flush ? invalid : EX.
  - EX <= (flush | bubble | !id_valid | !id_reg_write) ? invalid : {1, id_dst, id_mem_read}.
- Counters saturate at all-ones and do not wrap. stall_cycles increments on every cycle with stall=0 caused by a hazard; branch flushes are not counted.

## Timing
- All outputs are combinational from current ID inputs and registered slots; the block adds no latency to the pipeline.
- RAW distance 1 without forwarding: 2 bubble cycles. Distance 2: 1 bubble. Distance 3+: none.
- Load-use with FORWARD_EN: exactly 1 bubble.
- Reset (asynchronous, any time, including mid-stall): slots invalid, counters 0.
- Outputs during and after reset, before any ID input is valid: stall=1, pc_write=1, ifid_write=1, all flushes 0.
- Releasing rst_n mid-program restarts with an empty scoreboard. No hazard carries over.

## Configuration
- HAZARD_FORWARD_EN defined: an EX/MEM-to-EX forwarding unit exists. Only a match against the EX slot with is_load=1 hazards; MEM-slot and non-load EX matches pass. The jr rule is unchanged.
- Undefined: the full stall rule above applies.

## Structure
- Shared package `pipe_pkg`:
  - REG_ADDR_W default.
  - Scoreboard-slot struct {valid, dst, is_load}.
  - Bubble control-word constant (all zero).
- One sub-module, `sat_counter` (parameter CNT_W; inputs clk, rst_n, inc), instantiated twice for the counters.

## Test plan
- Load-use hazard, default build:
  - Stimulus: lw $8 followed by add $9,$8,$1.
  - Required: 2 cycles of stall=0 with pc_write=ifid_write=0, then the add passes; stall_cycles=2.
- Same load-use pair, HAZARD_FORWARD_EN build: exactly 1 bubble; stall_cycles=1. An add-after-add dependency gives 0 bubbles.
- $0 and don't-use cases:
  - Writer to $0 followed by a reader of $0: no stall.
  - id_uses_rt=0 with an rt match: no stall.
- Taken branch:
  - Stimulus: mem_branch_taken=1 with id_j=1 and an EX-slot hazard present in the same cycle.
  - Required: all three flushes = 1, pc_write=1, flush_events +1.
  - Next cycle both slots invalid; no stall.
- jr with rs written by the previous instruction, both builds: 2 bubbles, then flush_ifid=1 on the issue cycle.
- Reset and counter saturation:
  - rst_n low mid-stall: slots cleared, counters 0, stall=1 immediately.
  - CNT_W=2 with 5 hazard bubbles: stall_cycles holds at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: scoreboard slot, bubble control word and the RAW match helper.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  is_load;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

    typedef logic [15:0] ctrl_word_t;
    localparam ctrl_word_t CTRL_BUBBLE = '0;

    // $0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic slot_hit(input sb_slot_t s,
                                      input logic [REG_ADDR_W-1:0] src,
                                      input logic use_src);
        return use_src & s.valid & (s.dst == src) & (src != '0);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage hazard interface: decoded ID fields in, pipeline steering and counters out.
interface hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_j;
    logic                  id_jr;
    logic                  mem_branch_taken;
    logic                  stall;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  flush_ifid;
    logic                  flush_idex;
    logic                  flush_exmem;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
               id_mem_read, id_dst, id_j, id_jr, mem_branch_taken,
        input  stall, pc_write, ifid_write, flush_ifid, flush_idex, flush_exmem,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
               id_mem_read, id_dst, id_j, id_jr, mem_branch_taken,
        output stall, pc_write, ifid_write, flush_ifid, flush_idex, flush_exmem,
               stall_cycles, flush_events
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// RAW hazard / redirect controller beside ID, tracking EX and MEM destinations.
// Build option: HAZARD_FORWARD_EN (only load-in-EX dependencies stall; jr still stalls on EX/MEM).
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hz
);
    import pipe_pkg::*;

    sb_slot_t r_ex;
    sb_slot_t r_mem;

    logic w_hit_ex_rs, w_hit_ex_rt, w_hit_mem_rs, w_hit_mem_rt;
    logic w_data_hazard, w_jr_hazard, w_hazard, w_jump, w_branch;
    logic w_stall, w_pc_write, w_ifid_write;
    logic w_flush_ifid, w_flush_idex, w_flush_exmem;
    logic w_bubble, w_redirect;
    logic [CNT_W-1:0] w_stall_cycles, w_flush_events;

    assign w_hit_ex_rs  = hz.id_valid & slot_hit(r_ex,  hz.id_rs, hz.id_uses_rs | hz.id_jr);
    assign w_hit_ex_rt  = hz.id_valid & slot_hit(r_ex,  hz.id_rt, hz.id_uses_rt);
    assign w_hit_mem_rs = hz.id_valid & slot_hit(r_mem, hz.id_rs, hz.id_uses_rs | hz.id_jr);
    assign w_hit_mem_rt = hz.id_valid & slot_hit(r_mem, hz.id_rt, hz.id_uses_rt);

    // jr consumes rs in ID itself, where no forward path exists.
    assign w_jr_hazard = hz.id_jr & (w_hit_ex_rs | w_hit_mem_rs);

`ifdef HAZARD_FORWARD_EN
    assign w_data_hazard = r_ex.is_load & (w_hit_ex_rs | w_hit_ex_rt);
`else
    assign w_data_hazard = w_hit_ex_rs | w_hit_ex_rt | w_hit_mem_rs | w_hit_mem_rt;
`endif

    assign w_hazard = w_data_hazard | w_jr_hazard;
    assign w_jump   = hz.id_valid & (hz.id_j | hz.id_jr);
    assign w_branch = hz.mem_branch_taken;

    always_comb begin
        w_stall       = 1'b1;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_flush_exmem = 1'b0;
        w_bubble      = 1'b0;
        w_redirect    = 1'b0;
        if (w_branch) begin
            w_stall       = 1'b0;
            w_flush_ifid  = 1'b1;
            w_flush_idex  = 1'b1;
            w_flush_exmem = 1'b1;
            w_redirect    = 1'b1;
        end else if (w_hazard) begin
            w_stall      = 1'b0;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
        end else if (w_jump) begin
            w_flush_ifid = 1'b1;
            w_redirect   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= SLOT_EMPTY;
            r_mem <= SLOT_EMPTY;
        end else begin
            r_mem <= w_branch ? SLOT_EMPTY : r_ex;
            if (w_branch || w_bubble || !hz.id_valid || !hz.id_reg_write) begin
                r_ex <= SLOT_EMPTY;
            end else begin
                r_ex <= '{valid: 1'b1, dst: hz.id_dst, is_load: hz.id_mem_read};
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_bubble),
        .o_count (w_stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (w_redirect),
        .o_count (w_flush_events)
    );

    assign hz.stall        = w_stall;
    assign hz.pc_write     = w_pc_write;
    assign hz.ifid_write   = w_ifid_write;
    assign hz.flush_ifid   = w_flush_ifid;
    assign hz.flush_idex   = w_flush_idex;
    assign hz.flush_exmem  = w_flush_exmem;
    assign hz.stall_cycles = w_stall_cycles;
    assign hz.flush_events = w_flush_events;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; a second CNT_W=2 instance shares the stimulus for saturation.
module tb_hazard_unit;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_sc = 0;
    int   exp_fe = 0;
    int   bub;
    logic fl;

    always #5 clk = ~clk;

    hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(16)) hif ();
    hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  hif2 ();

    assign hif2.id_valid         = hif.id_valid;
    assign hif2.id_rs            = hif.id_rs;
    assign hif2.id_rt            = hif.id_rt;
    assign hif2.id_uses_rs       = hif.id_uses_rs;
    assign hif2.id_uses_rt       = hif.id_uses_rt;
    assign hif2.id_reg_write     = hif.id_reg_write;
    assign hif2.id_mem_read      = hif.id_mem_read;
    assign hif2.id_dst           = hif.id_dst;
    assign hif2.id_j             = hif.id_j;
    assign hif2.id_jr            = hif.id_jr;
    assign hif2.mem_branch_taken = hif.mem_branch_taken;

    hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw, input logic mr,
                       input logic [4:0] dst, input logic j, input logic jr, input logic br);
        hif.id_valid         = v;
        hif.id_rs            = rs;
        hif.id_rt            = rt;
        hif.id_uses_rs       = urs;
        hif.id_uses_rt       = urt;
        hif.id_reg_write     = rw;
        hif.id_mem_read      = mr;
        hif.id_dst           = dst;
        hif.id_j             = j;
        hif.id_jr            = jr;
        hif.mem_branch_taken = br;
    endtask

    task automatic idle(input int n);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the instruction currently driven until it passes (bounded), then advance one cycle.
    task automatic hold_issue(input string tag, output int bubbles, output logic fl_ifid);
        bubbles = 0;
        fl_ifid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (hif.stall) break;
            chk({tag, "_pcw_held"}, hif.pc_write, 0);
            chk({tag, "_ifidw_held"}, hif.ifid_write, 0);
            bubbles++;
            @(posedge clk);
            #1;
        end
        fl_ifid = hif.flush_ifid;
        @(posedge clk);
        #1;
        idle(0);
    endtask

    task automatic alu(input string tag, input logic [4:0] dst, input logic [4:0] rs,
                       input logic [4:0] rt, output int bubbles);
        logic f;
        drv(1, rs, rt, 1, 1, 1, 0, dst, 0, 0, 0);
        hold_issue(tag, bubbles, f);
    endtask

    task automatic jr_op(input string tag, input logic [4:0] rs, output int bubbles,
                         output logic f);
        drv(1, rs, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        hold_issue(tag, bubbles, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_stall", hif.stall, 1);
        chk("rst_pc_write", hif.pc_write, 1);
        chk("rst_ifid_write", hif.ifid_write, 1);
        chk("rst_flushes", {hif.flush_ifid, hif.flush_idex, hif.flush_exmem}, 0);
        chk("rst_stall_cycles", hif.stall_cycles, 0);
        chk("rst_flush_events", hif.flush_events, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_stall", hif.stall, 1);

        // lw $8,0($2) ; add $9,$8,$1
        drv(1, 5'd2, 0, 1, 0, 1, 1, 5'd8, 0, 0, 0);
        hold_issue("lw", bub, fl);
        chk("lw_bubbles", bub, 0);
        alu("loaduse", 5'd9, 5'd8, 5'd1, bub);
        chk("loaduse_bubbles", bub, FWD ? 1 : 2);
        exp_sc += FWD ? 1 : 2;
        chk("loaduse_stall_cycles", hif.stall_cycles, exp_sc);
        idle(2);

        alu("aa_w", 5'd10, 5'd1, 5'd2, bub);
        alu("aa_r", 5'd11, 5'd10, 5'd3, bub);
        chk("addadd_d1_bubbles", bub, FWD ? 0 : 2);
        exp_sc += FWD ? 0 : 2;
        idle(2);

        alu("d2_w", 5'd12, 5'd1, 5'd2, bub);
        idle(1);
        alu("d2_r", 5'd15, 5'd12, 5'd3, bub);
        chk("dist2_bubbles", bub, FWD ? 0 : 1);
        exp_sc += FWD ? 0 : 1;
        idle(2);

        alu("d3_w", 5'd12, 5'd1, 5'd2, bub);
        idle(2);
        alu("d3_r", 5'd16, 5'd3, 5'd12, bub);
        chk("dist3_bubbles", bub, 0);
        chk("stall_cycles_sum", hif.stall_cycles, exp_sc);
        idle(2);

        alu("z_w", 5'd0, 5'd1, 5'd2, bub);
        alu("z_r", 5'd17, 5'd0, 5'd0, bub);
        chk("reg0_bubbles", bub, 0);
        idle(2);

        alu("nu_w", 5'd7, 5'd1, 5'd2, bub);
        drv(1, 5'd1, 5'd7, 1, 0, 1, 0, 5'd18, 0, 0, 0);
        hold_issue("nu_r", bub, fl);
        chk("uses_rt0_bubbles", bub, 0);
        idle(2);

        alu("jr_w", 5'd5, 5'd1, 5'd2, bub);
        jr_op("jr", 5'd5, bub, fl);
        chk("jr_bubbles", bub, 2);
        chk("jr_flush_ifid", fl, 1);
        exp_sc += 2;
        exp_fe += 1;
        chk("jr_flush_events", hif.flush_events, exp_fe);
        chk("jr_stall_cycles", hif.stall_cycles, exp_sc);
        idle(2);

        // Taken branch in MEM overrides a jump and an EX hazard in the same cycle.
        alu("br_w", 5'd13, 5'd1, 5'd2, bub);
        drv(1, 5'd13, 0, 1, 0, 1, 0, 5'd14, 1, 0, 1);
        @(negedge clk);
        chk("br_stall", hif.stall, 0);
        chk("br_pc_write", hif.pc_write, 1);
        chk("br_flushes", {hif.flush_ifid, hif.flush_idex, hif.flush_exmem}, 3'b111);
        @(posedge clk);
        #1;
        exp_fe += 1;
        chk("br_flush_events", hif.flush_events, exp_fe);
        chk("br_stall_cycles", hif.stall_cycles, exp_sc);
        drv(1, 5'd13, 0, 1, 0, 1, 0, 5'd14, 0, 0, 0);
        @(negedge clk);
        chk("post_br_stall", hif.stall, 1);
        @(posedge clk);
        #1;
        idle(2);

        // Asynchronous reset while a hazard is holding the pipeline.
        alu("rs_w", 5'd14, 5'd1, 5'd2, bub);
        drv(1, 5'd14, 0, 1, 0, 1, 0, 5'd19, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_stall", hif.stall, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", hif.stall, 1);
        chk("midrst_pc_write", hif.pc_write, 1);
        chk("midrst_stall_cycles", hif.stall_cycles, 0);
        chk("midrst_flush_events", hif.flush_events, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_stall", hif.stall, 1);
        @(posedge clk);
        #1;
        idle(2);

        // Six jr bubbles: wide counter counts them, CNT_W=2 counter sticks at 3.
        for (int i = 0; i < 3; i++) begin
            alu("sat_w", 5'(20 + i), 5'd1, 5'd2, bub);
            jr_op("sat_jr", 5'(20 + i), bub, fl);
            chk("sat_jr_bubbles", bub, 2);
            idle(1);
        end
        chk("sat_wide_stall_cycles", hif.stall_cycles, 6);
        chk("sat_narrow_stall_cycles", hif2.stall_cycles, 3);
        chk("sat_wide_flush_events", hif.flush_events, 3);
        chk("sat_narrow_flush_events", hif2.flush_events, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
